tile_judge: RTL
===============

# tile_judge

Player-side judge for the piano-tiles game. It consumes the 4-column tile row stream that the LED/tile generator emits once per row-advance strobe. It compares debounced-free, synchronized pushbutton presses against the row currently at the hit line, and maintains score, combo and lives with a game-over state. It sits between the board pushbuttons and the display/HEX logic, in the same CLOCK_50 domain as the tile generator.

## Interface
- SCORE_W, 8: width of the score counter (saturating).
- LIVES, 3: lives loaded at reset; range 1..7.
- CLOCK_50 input 1: system clock; one clock domain, all logic on posedge.
- resetn input 1: reset, synchronous, active-low.
- tick input 1: one-cycle row-advance strobe from the tile generator.
- row input 4: tile row entering the hit line; valid only when tick=1; bit i = column i.
- KEY input 4: raw board pushbuttons, active-low (pressed = 0), asynchronous.
- pending output 4: tiles of the current row not yet hit.
- score output SCORE_W: total hits.
- combo output 8: consecutive hits since the last miss.
- lives output 3: remaining lives.
- hit_pulse output 1: one-cycle pulse when at least one hit registers.
- miss_pulse output 1: one-cycle pulse when a life is lost.
- game_over output 1: high while in OVER.

## Operation
- Key path: invert KEY, then pass it through a two-flop synchronizer (s1, s2) and a history flop s3. A press is detected as press[i] = s2[i] & ~s3[i]. Holding a key produces exactly one press.
- States:
  - IDLE: tick and row are ignored. Any press sets armed. On the next tick with armed=1, load pending<=row and go to PLAY. The press that arms is not judged.
  - PLAY: per cycle, the tick is processed first, then presses.
    - Tick: leftover = |pending. Then pending<=row.
    - Presses: each press is judged against pending after the tick update. A bit with pending=1 is a hit; clear that bit. A bit with pending=0 is a wrong press.
  - OVER: all inputs ignored, outputs frozen, game_over=1. Only resetn leaves OVER.
- Hits: score += popcount(hits), saturating at 2^SCORE_W-1. combo += popcount(hits), saturating at 255. hit_pulse=1 if hits≠0.
- Miss: miss = leftover | wrong-press. At most one life is lost per cycle, however many causes coincide. When miss=1, lives-=1 (floor 0), combo<=0, miss_pulse=1.
- A hit and a miss in the same cycle: score gets the hits, combo ends at 0, and both pulses fire.
- If lives reaches 0 on a cycle, enter OVER on that same edge; game_over is high from the next cycle.
- Reset values: state IDLE, armed 0, s1/s2/s3 0, pending 0, score 0, combo 0, lives LIVES, hit_pulse 0, miss_pulse 0, game_over 0.
- Reset mid-game returns all registers to their reset values on the first edge where resetn=0, and holds them while resetn=0. Any in-flight presses in s1..s3 are discarded.

## Timing
- A KEY falling transition first sampled at edge E0 is registered in s1 at E0, s2 at E1 and detected in the cycle after E1. score, combo, lives, pending and the pulses update at E2 (two-edge latency).
- Tick at edge T: pending shows the new row after T. A leftover miss from the old row is reflected in lives/miss_pulse after T.
- A press detected in the same cycle as tick is judged against the new row, never the old one.
- Pulses last exactly one cycle and are not stretched. Back-to-back hit cycles give back-to-back pulses.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset and arm: hold resetn=0 for 2 cycles → score=0, combo=0, lives=3, pending=0, game_over=0. Press KEY[0], then tick with row=4'b0101 → PLAY, pending=0101, score=0.
- Hit latency: in PLAY with pending=0101, drop KEY[2] at edge E0 → pending=0001, score=1, combo=1, hit_pulse high for 1 cycle after E2. Holding KEY[2] for 10 more cycles causes no further change.
- Wrong press and leftover together: pending=0001, press KEY[3] in the same cycle as a tick (row=1000) → KEY[3] is a hit on the new row. Leftover bit0 costs exactly one life: lives 3→2, combo=0, score+1, both pulses high.
- Double hit: pending=0110, press KEY[1] and KEY[2] simultaneously → score+2, combo+2, a single hit_pulse, pending=0.
- Game over: with LIVES=3, let three ticks pass with unhit rows → lives 3→2→1→0, game_over=1 on the cycle after the third miss. Further ticks and presses leave every output frozen. Then resetn=0 for one edge → all outputs return to their reset values.
- Saturation: with SCORE_W=4, score 15 plus one hit → score stays 15 and combo still increments.

Source files
------------

// File: rtl/tile_judge_if.sv
// Bundles the tile-stream and pushbutton inputs with the judge's score/lives outputs.
// master = tile generator / board side, slave = the judge.
interface tile_judge_if #(
  parameter int SCORE_W = 8
);
  logic               tick;
  logic [3:0]         row;
  logic [3:0]         KEY;
  logic [3:0]         pending;
  logic [SCORE_W-1:0] score;
  logic [7:0]         combo;
  logic [2:0]         lives;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport master (
    output tick, row, KEY,
    input  pending, score, combo, lives, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  tick, row, KEY,
    output pending, score, combo, lives, hit_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/tile_judge.sv
// Piano-tiles judge: synchronizes pushbuttons, judges presses against the row at the hit
// line, and keeps score, combo and lives until lives run out.
module tile_judge #(
  parameter int SCORE_W = 8,
  parameter int LIVES   = 3
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  tile_judge_if.slave  judge_io
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic [3:0]         s1_q, s2_q, s3_q;
  logic [3:0]         pending_q, pending_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic [2:0]         lives_q, lives_d;
  logic               hitPulse_q, hitPulse_d;
  logic               missPulse_q, missPulse_d;
  logic               gameOver_q, gameOver_d;

  logic [3:0]         press;
  logic [3:0]         rowNow;
  logic [3:0]         hits;
  logic               leftover;
  logic               wrongPress;
  logic               miss;
  logic [2:0]         hitCount;
  logic [SCORE_W:0]   scoreSum;
  logic [8:0]         comboSum;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      s1_q        <= 4'b0;
      s2_q        <= 4'b0;
      s3_q        <= 4'b0;
      pending_q   <= 4'b0;
      score_q     <= '0;
      combo_q     <= 8'd0;
      lives_q     <= LIVES_INIT;
      hitPulse_q  <= 1'b0;
      missPulse_q <= 1'b0;
      gameOver_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      s1_q        <= ~judge_io.KEY;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pending_q   <= pending_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      lives_q     <= lives_d;
      hitPulse_q  <= hitPulse_d;
      missPulse_q <= missPulse_d;
      gameOver_q  <= gameOver_d;
    end
  end

  // The tick replaces the row before presses are judged, so a press coinciding
  // with a tick always lands on the new row.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    pending_d   = pending_q;
    score_d     = score_q;
    combo_d     = combo_q;
    lives_d     = lives_q;
    hitPulse_d  = 1'b0;
    missPulse_d = 1'b0;
    press       = s2_q & ~s3_q;
    rowNow      = judge_io.tick ? judge_io.row : pending_q;
    leftover    = judge_io.tick & (|pending_q);
    hits        = press & rowNow;
    wrongPress  = |(press & ~rowNow);
    miss        = leftover | wrongPress;
    hitCount    = popcount4(hits);
    scoreSum    = {1'b0, score_q} + (SCORE_W + 1)'(hitCount);
    comboSum    = {1'b0, combo_q} + 9'(hitCount);

    case (state_q)
      IDLE: begin
        if (|press) begin
          armed_d = 1'b1;
        end
        if (judge_io.tick && armed_q) begin
          pending_d = judge_io.row;
          armed_d   = 1'b0;
          state_d   = PLAY;
        end
      end

      PLAY: begin
        pending_d  = rowNow & ~hits;
        hitPulse_d = |hits;
        score_d    = scoreSum[SCORE_W] ? SCORE_MAX : scoreSum[SCORE_W-1:0];
        if (miss) begin
          missPulse_d = 1'b1;
          combo_d     = 8'd0;
          lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          if (lives_d == 3'd0) begin
            state_d = OVER;
          end
        end else begin
          combo_d = comboSum[8] ? 8'hFF : comboSum[7:0];
        end
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    gameOver_d = (state_d == OVER);
  end

  assign judge_io.pending    = pending_q;
  assign judge_io.score      = score_q;
  assign judge_io.combo      = combo_q;
  assign judge_io.lives      = lives_q;
  assign judge_io.hit_pulse  = hitPulse_q;
  assign judge_io.miss_pulse = missPulse_q;
  assign judge_io.game_over  = gameOver_q;

endmodule
